// File: rtl/arb_rr.sv
// arb_rr: registered round-robin arbiter with a valid/ready grant handshake.
// Two priority-to-one-hot converters (masked and unmasked) pick the rightmost
// eligible request; a rotating mask gives every requester a turn within WIDTH
// accepted grants.
// Optional feature macro: ARB_RR_LOCK_EN (adds the lck burst-lock input).

// Priority-to-one-hot converter: keeps only the rightmost set bit of req.
// The vector is zero-padded up to a power of SPLIT; padded bits can never win.
module arb_rr_pri2oht #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht
);
    // Smallest power of the split factor that covers WIDTH.
    function automatic int pad_width(input int w, input int s);
        int p;
        int f;
        p = 1;
        f = (s < 2) ? 2 : s;
        while (p < w) begin
            p = p * f;
        end
        return p;
    endfunction

    localparam int PW = pad_width(WIDTH, SPLIT);

    logic [PW-1:0] req_pad_s;
    logic [PW-1:0] oht_pad_s;

    assign req_pad_s = PW'(req);
    assign oht       = oht_pad_s[WIDTH-1:0];

    generate
        if (IMPLEMENTATION == 0) begin : g_arith
            // Two's-complement trick isolates the lowest set bit.
            assign oht_pad_s = req_pad_s & (~req_pad_s + {{(PW-1){1'b0}}, 1'b1});
        end else begin : g_scan
            logic found_s;
            // Linear scan from bit 0 upward, first hit wins.
            always_comb begin
                oht_pad_s = {PW{1'b0}};
                found_s   = 1'b0;
                for (int i = 0; i < PW; i++) begin
                    if (req_pad_s[i] && !found_s) begin
                        oht_pad_s[i] = 1'b1;
                        found_s      = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end
        end
    endgenerate
endmodule

module arb_rr #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req,
    output logic [WIDTH-1:0]         oht,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     vld,
    input  logic                     rdy
`ifdef ARB_RR_LOCK_EN
    ,
    input  logic                     lck
`endif
);
    localparam int IDX_W = $clog2(WIDTH);

    // Binary encoding of a one-hot (or zero) vector.
    function automatic logic [IDX_W-1:0] enc_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r = r | IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] oht_r;
    logic [IDX_W-1:0] idx_r;
    logic             vld_r;
    logic [WIDTH-1:0] ptr_r;

    logic             load_s;
    logic             hs_s;
    logic             lock_hold_s;
    logic [WIDTH-1:0] above_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] masked_req_s;
    logic [WIDTH-1:0] grant_m_s;
    logic [WIDTH-1:0] grant_u_s;
    logic [WIDTH-1:0] sel_s;

    assign oht = oht_r;
    assign idx = idx_r;
    assign vld = vld_r;

    assign load_s = !vld_r || rdy;
    assign hs_s   = vld_r && rdy;

    // Bits strictly above the current grant; zero when the grant is the top bit.
    assign above_s = ~(oht_r | (oht_r - {{(WIDTH-1){1'b0}}, 1'b1}));

    // On a handshake the fresh mask comes from the grant being accepted, so
    // back-to-back arbitration advances without waiting for ptr_r to settle.
    assign mask_s       = hs_s ? above_s : ptr_r;
    assign masked_req_s = req & mask_s;

    arb_rr_pri2oht #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_pri_masked (
        .req(masked_req_s),
        .oht(grant_m_s)
    );

    arb_rr_pri2oht #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_pri_unmasked (
        .req(req),
        .oht(grant_u_s)
    );

    // Burst lock: keep the accepted grant while its requester still asks.
    always_comb begin
        lock_hold_s = 1'b0;
`ifdef ARB_RR_LOCK_EN
        if (hs_s && lck && |(req & oht_r)) begin
            lock_hold_s = 1'b1;
        end else begin
            lock_hold_s = 1'b0;
        end
`endif
    end

    // Grant selection: locked grant, else masked winner, else unmasked winner.
    always_comb begin
        sel_s = {WIDTH{1'b0}};
        if (lock_hold_s) begin
            sel_s = oht_r;
        end else if (|masked_req_s) begin
            sel_s = grant_m_s;
        end else begin
            sel_s = grant_u_s;
        end
    end

    // Output registers and rotating pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            oht_r <= {WIDTH{1'b0}};
            idx_r <= {IDX_W{1'b0}};
            vld_r <= 1'b0;
            ptr_r <= {WIDTH{1'b0}};
        end else begin
            if (load_s) begin
                vld_r <= |req;
                oht_r <= sel_s;
                idx_r <= enc_idx(sel_s);
            end else begin
                vld_r <= vld_r;
                oht_r <= oht_r;
                idx_r <= idx_r;
            end
            if (hs_s && !lock_hold_s) begin
                ptr_r <= above_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end
endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr at WIDTH=4 with hand-computed expected grants.
// Exercises ARB_RR_LOCK_EN when that macro is defined for the build.
module tb_arb_rr;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] req;
    logic [W-1:0] oht;
    logic [1:0]   idx;
    logic         vld;
    logic         rdy;
`ifdef ARB_RR_LOCK_EN
    logic         lck;
`endif

    int total;
    int bad;

    arb_rr #(.WIDTH(W), .SPLIT(2), .IMPLEMENTATION(0)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .oht(oht),
        .idx(idx),
        .vld(vld),
        .rdy(rdy)
`ifdef ARB_RR_LOCK_EN
        ,
        .lck(lck)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full registered output set.
    task automatic chk_out(input string tag, input logic [3:0] e_oht, input logic [1:0] e_idx,
                           input logic e_vld);
        chk({tag, ".oht"}, 32'(oht), 32'(e_oht));
        chk({tag, ".idx"}, 32'(idx), 32'(e_idx));
        chk({tag, ".vld"}, 32'(vld), 32'(e_vld));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b1111;
        rdy   = 1'b1;
`ifdef ARB_RR_LOCK_EN
        lck   = 1'b0;
`endif
        step();
        step();
        chk_out("reset", 4'b0000, 2'd0, 1'b0);

        // First grant one cycle after release.
        rst = 1'b0;
        step();
        chk_out("first", 4'b0001, 2'd0, 1'b1);

        // Rotation with all requests high.
        step(); chk_out("rot1", 4'b0010, 2'd1, 1'b1);
        step(); chk_out("rot2", 4'b0100, 2'd2, 1'b1);
        step(); chk_out("rot3", 4'b1000, 2'd3, 1'b1);
        step(); chk_out("rot4", 4'b0001, 2'd0, 1'b1);
        step(); chk_out("rot5", 4'b0010, 2'd1, 1'b1);

        // Stall: output holds while req changes.
        rdy = 1'b0;
        step(); chk_out("stall1", 4'b0010, 2'd1, 1'b1);
        req = 4'b0101;
        step(); chk_out("stall2", 4'b0010, 2'd1, 1'b1);
        step(); chk_out("stall3", 4'b0010, 2'd1, 1'b1);
        rdy = 1'b1;
        step(); chk_out("after_stall", 4'b0100, 2'd2, 1'b1);

        // Wrap past bit 3, then sparse requests.
        req = 4'b1111;
        step(); chk_out("to_bit3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0110;
        step(); chk_out("wrap", 4'b0010, 2'd1, 1'b1);
        req = 4'b0001;
        step(); chk_out("sparse", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        step(); chk_out("idle", 4'b0000, 2'd0, 1'b0);
        step(); chk_out("idle2", 4'b0000, 2'd0, 1'b0);

        // Mid-operation reset drops a stalled grant.
        req = 4'b0100;
        rdy = 1'b0;
        step(); chk_out("pre_rst", 4'b0100, 2'd2, 1'b1);
        rst = 1'b1;
        step(); chk_out("mid_rst", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b1111;
        rdy = 1'b1;
        step(); chk_out("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_RR_LOCK_EN
        // Burst lock holds bit 0 for two handshakes, then rotation resumes.
        lck = 1'b1;
        step(); chk_out("lock1", 4'b0001, 2'd0, 1'b1);
        step(); chk_out("lock2", 4'b0001, 2'd0, 1'b1);
        lck = 1'b0;
        step(); chk_out("unlock", 4'b0010, 2'd1, 1'b1);
        // Lock requested but the locked requester dropped: normal arbitration.
        lck = 1'b1;
        req = 4'b1001;
        step(); chk_out("lock_drop", 4'b1000, 2'd3, 1'b1);
        lck = 1'b0;
`else
        step(); chk_out("post_rst2", 4'b0010, 2'd1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arb_rr.md
Name: arb_rr

Overview:
- Registered round-robin arbiter that consumes a request vector and produces a one-hot grant with a valid/ready handshake.
- Sits directly downstream of the request sources and wraps the priority-to-one-hot converter: two instances, one masked and one unmasked, select the rightmost request.
- Holds a rotating pointer so every requester is served within WIDTH accepted grants.
- Output feeds muxes and one-hot consumers in the interconnect.

Parameters:
- WIDTH, 32, number of requesters; any value ≥ 2, not required to be a power of SPLIT.
- SPLIT, 2, tree split factor passed to the internal priority-to-one-hot instances.
- IMPLEMENTATION, 0, implementation selector passed to the internal priority-to-one-hot instances.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  WIDTH  request vector; bit i = requester i.
- oht  output  WIDTH  one-hot grant, registered.
- idx  output  $clog2(WIDTH)  binary index of the granted bit, registered.
- vld  output  1  grant valid.
- rdy  input  1  consumer accepts the grant.

Behaviour:
- Reset (rst=1 at an edge):
  - oht=0, idx=0, vld=0.
  - Pointer mask ptr=0, so the next search starts at bit 0.
  - Reset mid-transfer drops the pending grant with no handshake.
- Load condition: load = !vld || rdy.
  - On load: vld <= |req; oht <= selected grant; idx <= encoded index of that grant.
  - If req=0 on load: vld <= 0 and oht, idx <= 0.
- Selection (combinational from current req and ptr):
  - m = req & ptr.
  - If |m, grant = rightmost set bit of m; otherwise grant = rightmost set bit of req.
- Pointer update: only on a handshake (vld && rdy) at an edge.
  - ptr <= mask of bits strictly above the accepted grant.
  - Accepting bit WIDTH-1 gives ptr=0, so the search wraps to bit 0.
- Stall (vld && !rdy):
  - oht, idx and ptr hold.
  - Changes on req, including the granted request dropping, do not alter the output.
- Latency and throughput:
  - 1 cycle from req to vld when the output is idle.
  - Back-to-back grants: 1 per cycle while rdy=1.
- Simultaneous handshake and new request: the new grant uses req sampled in the same cycle and the ptr value before the update. Implementations must therefore compute the next mask from the accepted oht so that back-to-back arbitration is fair.
- Invariants:
  - oht is always one-hot or zero; oht=0 iff vld=0.
  - idx always matches oht.
- Fairness: with all requests held high, grants cycle 0,1,…,WIDTH-1,0.
- Non-power-of-SPLIT WIDTH: padding is handled inside the converter; padded bits never appear on oht.
- State summary:
  - IDLE (vld=0) → GRANT when |req.
  - GRANT → GRANT on a handshake with |req.
  - GRANT → IDLE on a handshake with req=0.
  - GRANT holds on a stall.

Optional Feature:
- Macro: ARB_RR_LOCK_EN.
- Defined: adds input port lck (1 bit), sampled during the handshake.
  - Handshake with lck=1 and req[idx] still set: the next grant is the same bit and ptr is not updated, giving burst lock.
  - Handshake with lck=1 and req[idx] cleared: normal arbitration applies.
- Undefined: no lck port; behaviour exactly as above.

Test Plan:
- Reset: WIDTH=4, rst=1 with req=4'b1111 → after release, first grant is oht=0001, idx=0, vld=1 one cycle later.
- Rotation: req=1111, rdy=1 constant → oht sequence 0001,0010,0100,1000,0001; vld never drops.
- Stall hold: oht=0010 with rdy=0 for 3 cycles while req changes 1111→0101 → oht stays 0010 and idx=1; after rdy=1, next oht=0100.
- Wrap and sparse: accept bit 3, then req=0110 → oht=0010; then req=0001 → oht=0001. With req=0 → vld=0 and oht=0.
- Mid-operation reset: vld=1, oht=0100, rdy=0, then rst pulse → vld=0, oht=0. Next grant with req=1111 is 0001.
- ARB_RR_LOCK_EN: req=1111, lck=1 for 2 handshakes → oht 0001,0001,0001; lck=0 → next oht=0010.
